uart_mmio: RTL and testbench
============================

# uart_mmio

Parametrised memory-mapped UART peripheral for the jacaranda-8 computer top level. It replaces the fixed-address flag/control/data decode and bare UART instance with one block: a four-register window at a configurable base address, TX and RX FIFOs of configurable depth, 8N1 serialiser/deserialiser with a parametrised bit period, and sticky error flags. It sits on the CPU data bus beside `data_mem`; the top level muxes `r_data` onto `mem_r_data` when `hit` is high.

## Interface
- `BASE_ADDR`, 8'd252: register window base; occupies BASE_ADDR..BASE_ADDR+3; must be a multiple of 4.
- `CLK_PER_BIT`, 16: clock cycles per serial bit; at least 4.
- `DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  8  CPU data address (`rs_data`).
- `w_data`  in  8  CPU store data (`rd_data`).
- `w_en`  in  1  store strobe (`mem_w_en`).
- `r_en`  in  1  load strobe; high for exactly one cycle per load instruction.
- `r_data`  out  8  combinational read data; 0 when `hit`=0.
- `hit`  out  1  combinational; `addr[7:2]==BASE_ADDR[7:2]`.
- `rx`  in  1  serial input; asynchronous, idle high.
- `tx`  out  1  serial output; idle high.

## Operation
- Register map (offset = `addr[1:0]`):
  - 0 RXDATA (R): head of RX FIFO; a read with `r_en` pops. Empty → reads 0, no pop.
  - 1 TXDATA (W): write pushes `w_data` to TX FIFO. Full → write dropped, no state change. Reads 0.
  - 2 STATUS (R): [0] tx_busy (shifter active or TX FIFO non-empty), [1] rx_avail, [2] tx_full, [3] rx_overrun (sticky), [4] frame_err (sticky), [7:5] 0.
  - 3 CONTROL (R/W): [0] tx_en, [1] rx_en; write bit 2 = 1 clears rx_overrun and frame_err (not stored, reads 0). Other bits read 0.
- Accesses with `hit`=0 have no effect.
- FIFOs: circular, pointers wrap modulo DEPTH, count width log2(DEPTH)+1. Simultaneous push and pop on the same FIFO: both occur, count unchanged; push to a full FIFO being popped that cycle is accepted.
- TX states IDLE → START → DATA(8, LSB first) → STOP → IDLE; each state lasts CLK_PER_BIT cycles. In IDLE with tx_en=1 and TX FIFO non-empty: pop and enter START. Clearing tx_en mid-frame finishes the current frame, then stops popping.
- RX: `rx` passes through a 2-flop synchroniser. States IDLE → START → DATA → STOP. In IDLE with rx_en=1, a falling edge enters START. The line is sampled at CLK_PER_BIT/2 into each bit. START sampled high → back to IDLE, no flag. STOP sampled 0 → byte discarded, frame_err set. STOP sampled 1 → byte pushed; if the FIFO is full, the byte is dropped and rx_overrun set. Clearing rx_en aborts any frame in progress (state → IDLE, no push).
- A flag set event and a clear write in the same cycle: set wins.

## Timing
- Reset values: `tx`=1, tx_en=rx_en=0, both FIFOs empty, flags 0, both FSMs IDLE. Reset mid-frame drives `tx`=1 from the next edge; partially received data is lost.
- Register writes take effect at the edge that samples `w_en`. `r_data` and `hit` have zero latency. A pop takes effect at the edge ending the load cycle.
- TXDATA write sampled at edge E with the shifter idle and tx_en=1: `tx` goes 0 from edge E+1. A frame lasts exactly 10×CLK_PER_BIT cycles; back-to-back FIFO bytes have no idle gap.
- RX: rx_avail rises 2 (synchroniser) + 9.5×CLK_PER_BIT cycles (±1) after the start-bit falling edge on `rx`.

## Test plan
- CLK_PER_BIT=4; reset, write CONTROL=0x01, write TXDATA=0xA5 → `tx` low one cycle after the write edge, then bits 1,0,1,0,0,1,0,1 then 1, each lasting 4 cycles; STATUS[0] falls at end of stop bit.
- DEPTH=4, tx_en=0: write 5 bytes → STATUS[2]=1 after the 4th; 5th dropped; set tx_en → exactly 4 frames sent, back-to-back.
- rx_en=1, drive 0x3C as 8N1 on `rx` → STATUS[1]=1; RXDATA read returns 0x3C and pops; next read returns 0, STATUS[1]=0.
- Drive 5 frames with no reads (DEPTH=4) → STATUS[3]=1; reads return the first 4 bytes in order; CONTROL write 0x07 clears bit 3.
- Frame with stop bit 0 → no push, STATUS[4]=1. A 1-cycle glitch low on `rx` → no push, no flag.
- Assert `reset` mid-TX frame → `tx`=1 at the next edge; STATUS reads 0; CONTROL reads 0.

Source files
------------

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: four-register window (RXDATA, TXDATA, STATUS, CONTROL),
// TX/RX FIFOs, parametrised bit period and sticky overrun/framing error flags.
module uart_mmio #(
   parameter logic [7:0] BASE_ADDR   = 8'd252,
   parameter int         CLK_PER_BIT = 16,
   parameter int         DEPTH       = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] addr,
   input  logic [7:0] w_data,
   input  logic       w_en,
   input  logic       r_en,
   output logic [7:0] r_data,
   output logic       hit,
   input  logic       rx,
   output logic       tx
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(CLK_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   // Bus decode
   logic [1:0] off;
   logic       wr_tx, wr_ctl, rd_rx, clr_flags;
   assign hit       = (addr[7:2] == BASE_ADDR[7:2]);
   assign off       = addr[1:0];
   assign wr_tx     = w_en && hit && (off == 2'd1);
   assign wr_ctl    = w_en && hit && (off == 2'd3);
   assign rd_rx     = r_en && hit && (off == 2'd0);
   assign clr_flags = wr_ctl && w_data[2];

   logic tx_en_q, rx_en_q, ovr_q, ferr_q;

   // TX FIFO
   logic [7:0]    txf_mem_q [DEPTH];
   logic [PW-1:0] txf_wp_q, txf_rp_q;
   logic [CW-1:0] txf_cnt_q, txf_cnt_d;
   logic          txf_empty, txf_full, tx_push, tx_pop;
   assign txf_empty = (txf_cnt_q == '0);
   assign txf_full  = (txf_cnt_q == CW'(DEPTH));
   assign tx_push   = wr_tx && (!txf_full || tx_pop);

   always_comb begin
      txf_cnt_d = txf_cnt_q;
      if (tx_push && !tx_pop) txf_cnt_d = txf_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) txf_cnt_d = txf_cnt_q - CW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         txf_wp_q  <= '0;
         txf_rp_q  <= '0;
         txf_cnt_q <= '0;
      end else begin
         if (tx_push) txf_wp_q <= txf_wp_q + PW'(1);
         if (tx_pop)  txf_rp_q <= txf_rp_q + PW'(1);
         txf_cnt_q <= txf_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (tx_push) txf_mem_q[txf_wp_q] <= w_data;
   end

   // RX FIFO
   logic [7:0]    rxf_mem_q [DEPTH];
   logic [PW-1:0] rxf_wp_q, rxf_rp_q;
   logic [CW-1:0] rxf_cnt_q, rxf_cnt_d;
   logic          rxf_empty, rxf_full, rx_pop, rx_done, rx_push, rxf_push, ovr_set, ferr_set;
   logic          rx_s2_q;
   logic [7:0]    rx_sh_q;
   assign rxf_empty = (rxf_cnt_q == '0);
   assign rxf_full  = (rxf_cnt_q == CW'(DEPTH));
   assign rx_pop    = rd_rx && !rxf_empty;
   assign rx_push   = rx_done && rx_s2_q;
   assign ferr_set  = rx_done && !rx_s2_q;
   assign rxf_push  = rx_push && (!rxf_full || rx_pop);
   assign ovr_set   = rx_push && rxf_full && !rx_pop;

   always_comb begin
      rxf_cnt_d = rxf_cnt_q;
      if (rxf_push && !rx_pop) rxf_cnt_d = rxf_cnt_q + CW'(1);
      else if (!rxf_push && rx_pop) rxf_cnt_d = rxf_cnt_q - CW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rxf_wp_q  <= '0;
         rxf_rp_q  <= '0;
         rxf_cnt_q <= '0;
      end else begin
         if (rxf_push) rxf_wp_q <= rxf_wp_q + PW'(1);
         if (rx_pop)   rxf_rp_q <= rxf_rp_q + PW'(1);
         rxf_cnt_q <= rxf_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (rxf_push) rxf_mem_q[rxf_wp_q] <= rx_sh_q;
   end

   // Control register and sticky flags; a set event beats a clear write
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_en_q <= 1'b0;
         rx_en_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         if (wr_ctl) begin
            tx_en_q <= w_data[0];
            rx_en_q <= w_data[1];
         end
         if (ovr_set)        ovr_q <= 1'b1;
         else if (clr_flags) ovr_q <= 1'b0;
         if (ferr_set)       ferr_q <= 1'b1;
         else if (clr_flags) ferr_q <= 1'b0;
      end
   end

   // TX serialiser; STOP chains straight into START when another byte waits
   state_e        tx_st_q;
   logic [TW-1:0] tx_cnt_q;
   logic [2:0]    tx_bit_q;
   logic [7:0]    tx_sh_q;
   logic          tx_q, tx_bit_end;
   assign tx_bit_end = (tx_cnt_q == BIT_LAST);
   assign tx_pop     = tx_en_q && !txf_empty &&
                       ((tx_st_q == S_IDLE) || ((tx_st_q == S_STOP) && tx_bit_end));
   assign tx         = tx_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_st_q  <= S_IDLE;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_q     <= 1'b1;
      end else begin
         tx_cnt_q <= (tx_st_q == S_IDLE || tx_bit_end) ? '0 : tx_cnt_q + TW'(1);
         case (tx_st_q)
            S_IDLE: if (tx_pop) begin
               tx_st_q <= S_START;
               tx_q    <= 1'b0;
            end
            S_START: if (tx_bit_end) begin
               tx_st_q  <= S_DATA;
               tx_bit_q <= '0;
               tx_q     <= tx_sh_q[0];
            end
            S_DATA: if (tx_bit_end) begin
               if (tx_bit_q == 3'd7) begin
                  tx_st_q <= S_STOP;
                  tx_q    <= 1'b1;
               end else begin
                  tx_bit_q <= tx_bit_q + 3'd1;
                  tx_q     <= tx_sh_q[1];
               end
            end
            S_STOP: if (tx_bit_end) begin
               tx_st_q <= tx_pop ? S_START : S_IDLE;
               tx_q    <= !tx_pop;
            end
            default: tx_st_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (tx_pop) tx_sh_q <= txf_mem_q[txf_rp_q];
      else if (tx_st_q == S_DATA && tx_bit_end) tx_sh_q <= {1'b0, tx_sh_q[7:1]};
   end

   // RX deserialiser; counter starts at 1 to absorb the edge-detect cycle
   state_e        rx_st_q;
   logic [TW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic          rx_s1_q, rx_prev_q, rx_bit_end;
   assign rx_bit_end = (rx_cnt_q == BIT_LAST);
   assign rx_done    = rx_en_q && (rx_st_q == S_STOP) && rx_bit_end;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !rx_en_q) begin
         rx_st_q  <= S_IDLE;
         rx_cnt_q <= TW'(1);
         rx_bit_q <= '0;
      end else begin
         case (rx_st_q)
            S_IDLE: begin
               rx_cnt_q <= TW'(1);
               if (rx_prev_q && !rx_s2_q) rx_st_q <= S_START;
            end
            S_START: if (rx_cnt_q == HALF_LAST) begin
               rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
               rx_cnt_q <= '0;
               rx_bit_q <= '0;
            end else rx_cnt_q <= rx_cnt_q + TW'(1);
            S_DATA: if (rx_bit_end) begin
               rx_cnt_q <= '0;
               rx_bit_q <= rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
            end else rx_cnt_q <= rx_cnt_q + TW'(1);
            S_STOP: if (rx_bit_end) begin
               rx_st_q  <= S_IDLE;
               rx_cnt_q <= TW'(1);
            end else rx_cnt_q <= rx_cnt_q + TW'(1);
            default: rx_st_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rx_st_q == S_DATA && rx_bit_end) rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
   end

   // Read mux
   logic [7:0] status;
   assign status = {3'b000, ferr_q, ovr_q, txf_full, !rxf_empty,
                    (tx_st_q != S_IDLE) || !txf_empty};

   always_comb begin
      r_data = 8'h00;
      if (hit) begin
         case (off)
            2'd0:    r_data = rxf_empty ? 8'h00 : rxf_mem_q[rxf_rp_q];
            2'd2:    r_data = status;
            2'd3:    r_data = {6'b000000, rx_en_q, tx_en_q};
            default: r_data = 8'h00;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with CLK_PER_BIT=4, DEPTH=4: register access,
// TX framing, RX reception, overrun/framing flags, glitch rejection and reset.
module tb_uart_mmio;
   localparam logic [7:0] RXD = 8'hFC, TXD = 8'hFD, STA = 8'hFE, CTL = 8'hFF;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] addr = 8'h00, w_data = 8'h00, r_data;
   logic       w_en = 1'b0, r_en = 1'b0, hit, rx = 1'b1, tx;
   int         n_checks = 0, n_fail = 0;
   logic [7:0] d;

   uart_mmio #(.BASE_ADDR(8'd252), .CLK_PER_BIT(4), .DEPTH(4)) dut (
      .clock(clock), .reset(reset), .addr(addr), .w_data(w_data), .w_en(w_en),
      .r_en(r_en), .r_data(r_data), .hit(hit), .rx(rx), .tx(tx)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] v);
      addr = a; w_data = v; w_en = 1'b1;
      tick();
      w_en = 1'b0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [7:0] v);
      addr = a; r_en = 1'b1;
      #1 v = r_data;
      tick();
      r_en = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, output logic [7:0] v);
      addr = a;
      #1 v = r_data;
   endtask

   // Checks tx every cycle of one 8N1 frame, starting with the first start-bit cycle
   task automatic expect_frame(input logic [7:0] b, input string tag);
      logic e;
      for (int j = 0; j < 10; j++) begin
         e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
         for (int c = 0; c < 4; c++) begin
            tick();
            check(tag, tx, e);
         end
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stopb);
      rx = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (4) tick();
      end
      rx = stopb;
      repeat (4) tick();
      rx = 1'b1;
   endtask

   initial begin
      logic [7:0] txb [5];
      logic [7:0] rxb [5];
      txb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      rxb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state and decode
      check("reset_tx", tx, 1'b1);
      peek(STA, d); check("reset_status", d, 8'h00);
      peek(CTL, d); check("reset_control", d, 8'h00);
      check("hit_in_window", hit, 1'b1);
      peek(8'h10, d); check("miss_rdata", d, 8'h00);
      check("miss_hit", hit, 1'b0);
      reg_write(8'h0F, 8'h03);
      peek(CTL, d); check("miss_write_ignored", d, 8'h00);
      peek(RXD, d); check("rx_empty_reads0", d, 8'h00);

      // Single TX frame 0xA5
      reg_write(CTL, 8'h01);
      reg_write(TXD, 8'hA5);
      check("tx_high_at_write_edge", tx, 1'b1);
      peek(STA, d); check("tx_busy_queued", d[0], 1'b1);
      peek(TXD, d); check("txdata_reads0", d, 8'h00);
      expect_frame(8'hA5, "tx_a5");
      peek(STA, d); check("busy_in_stop", d[0], 1'b1);
      tick();
      peek(STA, d); check("busy_after_stop", d[0], 1'b0);
      check("tx_idle", tx, 1'b1);

      // Fill TX FIFO with tx disabled, overflow, then drain back-to-back
      reg_write(CTL, 8'h00);
      for (int i = 0; i < 3; i++) reg_write(TXD, txb[i]);
      peek(STA, d); check("not_full_3", d[2], 1'b0);
      reg_write(TXD, txb[3]);
      peek(STA, d); check("full_4", d[2], 1'b1);
      reg_write(TXD, txb[4]);
      check("tx_held_disabled", tx, 1'b1);
      reg_write(CTL, 8'h01);
      for (int i = 0; i < 4; i++) expect_frame(txb[i], $sformatf("burst_%0d", i));
      tick();
      peek(STA, d); check("burst_done_status", d, 8'h00);
      for (int c = 0; c < 8; c++) begin
         tick();
         check("fifth_dropped", tx, 1'b1);
      end

      // Single RX byte
      reg_write(CTL, 8'h02);
      send_rx(8'h3C, 1'b1);
      repeat (2) tick();
      peek(STA, d); check("rx_avail", d[1], 1'b1);
      reg_read(RXD, d); check("rx_3c", d, 8'h3C);
      reg_read(RXD, d); check("rx_after_pop", d, 8'h00);
      peek(STA, d); check("rx_avail_clear", d[1], 1'b0);

      // RX overrun: five frames, four kept in order
      for (int i = 0; i < 5; i++) send_rx(rxb[i], 1'b1);
      repeat (2) tick();
      peek(STA, d); check("overrun_set", d[3], 1'b1);
      check("overrun_avail", d[1], 1'b1);
      for (int i = 0; i < 4; i++) begin
         reg_read(RXD, d); check($sformatf("rx_order_%0d", i), d, rxb[i]);
      end
      reg_read(RXD, d); check("rx_drained", d, 8'h00);
      reg_write(CTL, 8'h07);
      peek(STA, d); check("overrun_cleared", d[3], 1'b0);
      peek(CTL, d); check("ctl_bit2_not_stored", d, 8'h03);

      // Framing error and glitch rejection
      reg_write(CTL, 8'h02);
      send_rx(8'h5A, 1'b0);
      repeat (3) tick();
      peek(STA, d); check("frame_err_set", d[4], 1'b1);
      check("frame_err_no_push", d[1], 1'b0);
      reg_write(CTL, 8'h06);
      peek(STA, d); check("frame_err_cleared", d, 8'h00);
      rx = 1'b0;
      tick();
      rx = 1'b1;
      repeat (20) tick();
      peek(STA, d); check("glitch_ignored", d, 8'h00);

      // Reset in the middle of a TX frame
      reg_write(CTL, 8'h01);
      reg_write(TXD, 8'h00);
      reg_write(TXD, 8'h00);
      repeat (10) tick();
      check("tx_mid_frame_low", tx, 1'b0);
      reset = 1'b1;
      tick();
      check("tx_after_reset", tx, 1'b1);
      reset = 1'b0;
      peek(STA, d); check("status_after_reset", d, 8'h00);
      peek(CTL, d); check("control_after_reset", d, 8'h00);
      repeat (4) tick();
      check("tx_stays_idle", tx, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
